float_sign_pipe: RTL and testbench

- Parametrised, pipelined IEEE-754 sign-manipulation unit; successor to the fixed double-precision abs block.
- Supports any exponent/mantissa split (half/single/double), four sign operations, optional signalling-NaN quieting, classification flags, and configurable latency.
- Uses a valid/ready handshake so it drops into streaming float datapaths alongside the other arithmetic components.

---
 rtl/float_sign_pipe.sv | 110 +++++++++++
 tb/tb_float_sign_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/float_sign_pipe.sv
// Pipelined IEEE-754 sign unit: abs / negate / copysign / negative-abs with
// optional sNaN quieting, result classification and valid/ready flow control.
module float_sign_pipe #(
    parameter int EXP_W     = 11,
    parameter int MAN_W     = 52,
    parameter int LATENCY   = 2,
    parameter int QUIET_NAN = 1,
    localparam int W        = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [1:0]   in_op,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_z,
    output logic         out_nan,
    output logic         out_inf,
    output logic         out_zero,
    output logic         out_invalid,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam logic [MAN_W-1:0] MAN_MSB = MAN_W'(1) << (MAN_W - 1);

    typedef enum logic [1:0] {
        OP_ABS  = 2'b00,
        OP_NEG  = 2'b01,
        OP_COPY = 2'b10,
        OP_NABS = 2'b11
    } op_t;

    logic [EXP_W-1:0] a_exp;
    logic [MAN_W-1:0] a_man;
    logic [MAN_W-1:0] res_man;
    logic             res_sign;
    logic             exp_ones, exp_zero, man_zero;
    logic             c_nan, c_inf, c_zero, c_invalid;
    logic [W-1:0]     c_z;
    logic             advance;
    logic             unused_ok;

    assign a_exp     = in_a[W-2 -: EXP_W];
    assign a_man     = in_a[MAN_W-1:0];
    assign unused_ok = ^in_b[W-2:0];

    always_comb begin
        res_sign = 1'b0;
        case (op_t'(in_op))
            OP_ABS:  res_sign = 1'b0;
            OP_NEG:  res_sign = ~in_a[W-1];
            OP_COPY: res_sign = in_b[W-1];
            OP_NABS: res_sign = 1'b1;
            default: res_sign = 1'b0;
        endcase
    end

    assign exp_ones  = &a_exp;
    assign exp_zero  = ~|a_exp;
    assign man_zero  = ~|a_man;
    assign c_nan     = exp_ones & ~man_zero;
    assign c_inf     = exp_ones & man_zero;
    assign c_zero    = exp_zero & man_zero;
    // A NaN whose mantissa MSB is clear is signalling; quieting keeps it a NaN.
    assign c_invalid = (QUIET_NAN != 0) && c_nan && !a_man[MAN_W-1];
    assign res_man   = c_invalid ? (a_man | MAN_MSB) : a_man;
    assign c_z       = {res_sign, a_exp, res_man};

    logic [W-1:0]       st_z [LATENCY];
    logic [LATENCY-1:0] st_valid, st_nan, st_inf, st_zero, st_inv;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_valid <= '0;
            st_nan   <= '0;
            st_inf   <= '0;
            st_zero  <= '0;
            st_inv   <= '0;
            for (int i = 0; i < LATENCY; i++) st_z[i] <= '0;
        end else if (advance) begin
            st_valid[0] <= in_valid;
            st_z[0]     <= c_z;
            st_nan[0]   <= c_nan;
            st_inf[0]   <= c_inf;
            st_zero[0]  <= c_zero;
            st_inv[0]   <= c_invalid;
            for (int i = 1; i < LATENCY; i++) begin
                st_valid[i] <= st_valid[i-1];
                st_z[i]     <= st_z[i-1];
                st_nan[i]   <= st_nan[i-1];
                st_inf[i]   <= st_inf[i-1];
                st_zero[i]  <= st_zero[i-1];
                st_inv[i]   <= st_inv[i-1];
            end
        end
    end

    assign out_valid   = st_valid[LATENCY-1];
    assign out_z       = st_z[LATENCY-1];
    assign out_nan     = st_nan[LATENCY-1];
    assign out_inf     = st_inf[LATENCY-1];
    assign out_zero    = st_zero[LATENCY-1];
    assign out_invalid = st_inv[LATENCY-1];

endmodule

// File: tb/tb_float_sign_pipe.sv
// Directed and randomised checks of float_sign_pipe in double (L=2), double
// without quieting (L=1) and single precision (L=4) configurations.
module tb_float_sign_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // double, defaults
    logic [63:0] d_a, d_b, d_z;
    logic [1:0]  d_op;
    logic        d_valid, d_in_ready, d_nan, d_inf, d_zero, d_inv, d_out_valid, d_out_ready;
    // double, QUIET_NAN=0, LATENCY=1
    logic [63:0] q_a, q_b, q_z;
    logic [1:0]  q_op;
    logic        q_valid, q_in_ready, q_nan, q_inf, q_zero, q_inv, q_out_valid, q_out_ready;
    // single, LATENCY=4
    logic [31:0] s_a, s_b, s_z;
    logic [1:0]  s_op;
    logic        s_valid, s_in_ready, s_nan, s_inf, s_zero, s_inv, s_out_valid, s_out_ready;

    float_sign_pipe u_dbl (
        .clk(clk), .rst_n(rst_n), .in_a(d_a), .in_b(d_b), .in_op(d_op),
        .in_valid(d_valid), .in_ready(d_in_ready), .out_z(d_z), .out_nan(d_nan),
        .out_inf(d_inf), .out_zero(d_zero), .out_invalid(d_inv),
        .out_valid(d_out_valid), .out_ready(d_out_ready)
    );

    float_sign_pipe #(.EXP_W(11), .MAN_W(52), .LATENCY(1), .QUIET_NAN(0)) u_dq0 (
        .clk(clk), .rst_n(rst_n), .in_a(q_a), .in_b(q_b), .in_op(q_op),
        .in_valid(q_valid), .in_ready(q_in_ready), .out_z(q_z), .out_nan(q_nan),
        .out_inf(q_inf), .out_zero(q_zero), .out_invalid(q_inv),
        .out_valid(q_out_valid), .out_ready(q_out_ready)
    );

    float_sign_pipe #(.EXP_W(8), .MAN_W(23), .LATENCY(4), .QUIET_NAN(1)) u_sgl (
        .clk(clk), .rst_n(rst_n), .in_a(s_a), .in_b(s_b), .in_op(s_op),
        .in_valid(s_valid), .in_ready(s_in_ready), .out_z(s_z), .out_nan(s_nan),
        .out_inf(s_inf), .out_zero(s_zero), .out_invalid(s_inv),
        .out_valid(s_out_valid), .out_ready(s_out_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // flags packed as {nan, inf, zero, invalid}
    task automatic run_d(input string tag, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] ez, input logic [3:0] ef);
        @(negedge clk);
        d_op = op; d_a = a; d_b = b; d_valid = 1'b1; d_out_ready = 1'b1;
        chk({tag, "_in_ready"}, 64'(d_in_ready), 64'd1);
        @(negedge clk);
        d_valid = 1'b0;
        chk({tag, "_early_valid"}, 64'(d_out_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 64'(d_out_valid), 64'd1);
        chk({tag, "_z"}, d_z, ez);
        chk({tag, "_flags"}, 64'({d_nan, d_inf, d_zero, d_inv}), 64'(ef));
    endtask

    task automatic run_q(input string tag, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] ez, input logic [3:0] ef);
        @(negedge clk);
        q_op = op; q_a = a; q_b = '0; q_valid = 1'b1; q_out_ready = 1'b1;
        @(negedge clk);
        q_valid = 1'b0;
        chk({tag, "_valid"}, 64'(q_out_valid), 64'd1);
        chk({tag, "_z"}, q_z, ez);
        chk({tag, "_flags"}, 64'({q_nan, q_inf, q_zero, q_inv}), 64'(ef));
    endtask

    function automatic logic [35:0] model_s(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic       s;
        logic [7:0] e;
        logic [22:0] m;
        logic       nan, inf, zero, inv;
        e = a[30:23];
        m = a[22:0];
        case (op)
            2'b00:   s = 1'b0;
            2'b01:   s = ~a[31];
            2'b10:   s = b[31];
            default: s = 1'b1;
        endcase
        nan  = (e == 8'hFF) && (m != 0);
        inf  = (e == 8'hFF) && (m == 0);
        zero = (e == 8'h00) && (m == 0);
        inv  = nan && !m[22];
        if (inv) m[22] = 1'b1;
        return {nan, inf, zero, inv, s, e, m};
    endfunction

    logic [35:0] exp_q[$];
    int sent = 0;
    int pops = 0;

    task automatic cyc_s(input bit v, input bit r);
        logic [35:0] e;
        logic [31:0] ra;
        @(negedge clk);
        ra = $urandom;
        case ($urandom_range(0, 3))
            0:       ra[30:23] = 8'hFF;
            1:       ra[30:23] = 8'h00;
            default: ;
        endcase
        if ($urandom_range(0, 3) == 0) ra[22:0] = '0;
        s_a = ra; s_b = $urandom; s_op = 2'($urandom_range(0, 3));
        s_valid = v; s_out_ready = r;
        #1;
        chk("s_in_ready", 64'(s_in_ready), 64'(!(s_out_valid && !s_out_ready)));
        if (s_valid && s_in_ready) begin
            exp_q.push_back(model_s(s_op, s_a, s_b));
            sent++;
        end
        if (s_out_valid && s_out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL s_extra_beat: observed %h expected none", s_z);
            end else begin
                e = exp_q.pop_front();
                chk("s_z", 64'(s_z), 64'(e[31:0]));
                chk("s_flags", 64'({s_nan, s_inf, s_zero, s_inv}), 64'(e[35:32]));
                pops++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held;
        int          cyc;
        int          pops0;
        d_a = '0; d_b = '0; d_op = '0; d_valid = 1'b0; d_out_ready = 1'b1;
        q_a = '0; q_b = '0; q_op = '0; q_valid = 1'b0; q_out_ready = 1'b1;
        s_a = '0; s_b = '0; s_op = '0; s_valid = 1'b0; s_out_ready = 1'b1;

        #2;
        chk("rst_in_ready", 64'(d_in_ready), 64'd1);
        chk("rst_out_valid", 64'(d_out_valid), 64'd0);
        chk("rst_z", d_z, 64'd0);
        chk("rst_flags", 64'({d_nan, d_inf, d_zero, d_inv}), 64'd0);
        chk("rst_s_out_valid", 64'(s_out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_d("abs_m1",   2'b00, 64'hBFF0000000000000, 64'h0, 64'h3FF0000000000000, 4'b0000);
        run_d("copysign", 2'b10, 64'h4000000000000000, 64'h8000000000000000,
              64'hC000000000000000, 4'b0000);
        run_d("nabs_zero", 2'b11, 64'h0, 64'h0, 64'h8000000000000000, 4'b0010);
        run_d("neg_snan", 2'b01, 64'h7FF0000000000001, 64'h0, 64'hFFF8000000000001, 4'b1001);
        run_d("abs_inf",  2'b00, 64'h7FF0000000000000, 64'h0, 64'h7FF0000000000000, 4'b0100);
        run_d("abs_denorm", 2'b00, 64'h8000000000000001, 64'h0, 64'h0000000000000001, 4'b0000);
        run_d("neg_qnan", 2'b01, 64'h7FF8000000000000, 64'h0, 64'hFFF8000000000000, 4'b1000);
        run_d("copy_pos", 2'b10, 64'hC008000000000000, 64'h3FF0000000000000,
              64'h4008000000000000, 4'b0000);

        run_q("q0_neg_snan", 2'b01, 64'h7FF0000000000001, 64'hFFF0000000000001, 4'b1000);
        run_q("q0_nabs_one", 2'b11, 64'h3FF0000000000000, 64'hBFF0000000000000, 4'b0000);

        // random stream, 50% valid / 50% ready
        cyc = 0;
        while ((sent < 100 || exp_q.size() != 0) && cyc < 5000) begin
            cyc_s((sent < 100) && ($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1);
            cyc++;
        end
        chk("s_stream_done", 64'(pops), 64'd100);

        // fill, stall, drain
        for (int i = 0; i < 4; i++) cyc_s(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc_s(1'b1, 1'b0);
            chk("stall_in_ready", 64'(s_in_ready), 64'd0);
            chk("stall_valid", 64'(s_out_valid), 64'd1);
            if (i == 0) held = s_z;
            else chk("stall_z_held", 64'(s_z), 64'(held));
        end
        pops0 = pops;
        for (int i = 0; i < 4; i++) cyc_s(1'b0, 1'b1);
        chk("drain_count", 64'(pops - pops0), 64'd4);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        s_valid = 1'b0;

        // mid-stream async reset
        @(negedge clk);
        d_op = 2'b00; d_a = 64'hC000000000000000; d_valid = 1'b1; d_out_ready = 1'b0;
        @(negedge clk);
        d_a = 64'hC010000000000000;
        @(negedge clk);
        d_valid = 1'b0;
        chk("pre_rst_valid", 64'(d_out_valid), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(d_out_valid), 64'd0);
        chk("async_rst_z", d_z, 64'd0);
        chk("async_rst_in_ready", 64'(d_in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        d_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_stale_beat", 64'(d_out_valid), 64'd0);
        end
        run_d("post_rst", 2'b01, 64'h3FF0000000000000, 64'h0, 64'hBFF0000000000000, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
